jump_ras_ctrl: RTL and testbench
================================

// Module: jump_ras_ctrl
// PURPOSE
// D-stage jump resolver for j/jal/jr/jalr with a parametrised return-address stack (RAS).
// - jr $31 with a pending writer of $31 takes the RAS top instead of stalling.
// - Other register jumps with a hazard still raise jump_conflictD.
// - An internal E-stage record checks each RAS prediction against the forwarded rs value.
// - On a wrong prediction it raises mispredictE with the correct target.
// PARAMETERS
// RAS_DEPTH  8   RAS entries; power of 2, >=2
// CNT_W      16  width of the hit/miss performance counters
// PORTS
// clk             in   1   clock
// rst             in   1   synchronous reset, active high
// validD          in   1   instrD holds a real instruction
// stallD          in   1   D stage held this cycle
// stallE          in   1   E stage held this cycle
// flushE          in   1   E-stage bubble insert
// instrD          in   32  D-stage instruction
// pcplus4D        in   32  D-stage PC+4
// rd1D            in   32  rs read value in D
// regwriteE/M/W   in   1   stage writes the register file
// writeregE/M/W   in   5   destination register per stage
// rs_fwdE         in   32  fully forwarded rs value in E
// jumpD           out  1   D instruction is j/jal/jr/jalr
// jump_conflictD  out  1   register jump must stall D
// pc_jumpD        out  32  jump target chosen in D
// ras_predD       out  1   pc_jumpD came from the RAS
// mispredictE     out  1   RAS prediction in E was wrong
// pc_fixE         out  32  correct target; equals rs_fwdE
// ras_hits        out  CNT_W  count of correct RAS predictions
// ras_misses      out  CNT_W  count of wrong RAS predictions
// BEHAVIOUR
// Decode (combinational)
// - j    = op[31:27]==00001; jal = op==000011.
// - jr   = op==0 and funct[5:1]==00100; jalr = jr and funct[0].
// - ret  = jr and rs==31 and not jalr.
// - hazard = OR over E/M/W of (regwriteX and writeregX==rs).
// Target selection
// - j/jal: pc_jumpD = {pcplus4D[31:28], instr[25:0], 2'b00}; no conflict.
// - ret, hazard, RAS non-empty: pc_jumpD = RAS top; ras_predD=1; conflict=0.
// - Other jr/jalr: pc_jumpD = rd1D; conflict = hazard.
// - jumpD, jump_conflictD and ras_predD are gated by validD.
// Fire and RAS update
// - fire = validD & ~stallD & ~jump_conflictD.
// - Push on fire & (jal|jalr): value = pcplus4D+4 (skips delay slot).
// - Pop on fire & ret & count>0.
// - Pop when empty: no state change.
// - Circular buffer: ptr wraps mod RAS_DEPTH.
// - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
// - Push and pop in the same instruction cannot occur (ret excludes jalr).
// E record
// - Update when ~stallE: pred_vE <= fire & ras_predD; tgtE <= pc_jumpD.
// - flushE (when ~stallE) clears pred_vE; stallE holds the record.
// - mispredictE = pred_vE & (rs_fwdE != tgtE). Combinational and unregistered.
// - mispredictE empties the RAS next cycle (count=0).
// - The same-cycle D push/pop is discarded; the squashed D instruction must not update state.
// - On stallE the counters do not change.
// - pred_vE & ~stallE: increment ras_hits on match, ras_misses on mismatch.
// - Counters saturate at all-ones.
// Reset
// - RAS ptr, count, pred_vE, tgtE and both counters = 0.
// - mispredictE = 0.
// - Reset mid-operation aborts pending pushes and pops.
// TESTING
// - jal at pcplus4D=0x100 fires -> count=1, top=0x104.
// - Then jr $31 with regwriteE=1, writeregE=31 -> conflict=0, ras_predD=1, pc_jumpD=0x104.
// - E resolve, rs_fwdE=0x104 -> mispredictE=0; ras_hits=1.
// - Same case with rs_fwdE=0x200 -> mispredictE=1, pc_fixE=0x200; count=0 next cycle; ras_misses=1.
// - RAS empty, jr $31 with hazard in M -> jump_conflictD=1, ras_predD=0, no pop.
// - jr $5 with hazard in W -> conflict=1, pc_jumpD=rd1D.
// - RAS_DEPTH+1 jal pushes (targets 0x104, 0x204, ...) then RAS_DEPTH+1 rets.
//   -> Pops return newest-first; the oldest entry is lost; the last ret stalls on its hazard.
// - jal held with stallD=1 for 3 cycles -> exactly one push.
// - flushE with pred_vE=1 -> mispredictE stays 0; counters unchanged.
// - rst asserted mid-sequence -> all state 0 next cycle.

Source files
------------

// File: rtl/jump_ras_ctrl.sv
// ============================================================================
// Module      : jump_ras_ctrl
// Description : D-stage jump resolver (j/jal/jr/jalr) with a return-address
//               stack and E-stage verification of RAS-predicted returns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_ras_ctrl #(
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD,
    input  logic             stallD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic [31:0]      instrD,
    input  logic [31:0]      pcplus4D,
    input  logic [31:0]      rd1D,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic [31:0]      rs_fwdE,
    output logic             jumpD,
    output logic             jump_conflictD,
    output logic [31:0]      pc_jumpD,
    output logic             ras_predD,
    output logic             mispredictE,
    output logic [31:0]      pc_fixE,
    output logic [CNT_W-1:0] ras_hits,
    output logic [CNT_W-1:0] ras_misses
);

    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int COUNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]        ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr;      // next write slot; top is ras_ptr-1
    logic [COUNT_W-1:0] ras_count;
    logic               pred_vE;
    logic [31:0]        tgtE;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic        is_j;
    logic        is_jal;
    logic        is_jr;
    logic        is_jalr;
    logic        is_ret;
    logic        hazard;
    logic        ras_nonempty;
    logic        use_ras;
    logic [31:0] ras_top;
    logic        fire;
    logic        push;
    logic        pop;

    assign op     = instrD[31:26];
    assign funct  = instrD[5:0];
    assign rs     = instrD[25:21];

    assign is_j    = (instrD[31:27] == 5'b00001);
    assign is_jal  = (op == 6'b000011);
    assign is_jr   = (op == 6'b000000) && (funct[5:1] == 5'b00100);
    assign is_jalr = is_jr && funct[0];
    assign is_ret  = is_jr && (rs == 5'd31) && !funct[0];

    assign hazard = (regwriteE && (writeregE == rs))
                  || (regwriteM && (writeregM == rs))
                  || (regwriteW && (writeregW == rs));

    assign ras_nonempty = (ras_count != '0);
    assign ras_top      = ras_mem[ras_ptr - PTR_W'(1)];
    // A return whose $31 is still in flight trusts the RAS instead of stalling
    assign use_ras      = is_ret && hazard && ras_nonempty;

    always_comb begin
        pc_jumpD = rd1D;
        if (is_j) begin
            pc_jumpD = {pcplus4D[31:28], instrD[25:0], 2'b00};
        end else if (use_ras) begin
            pc_jumpD = ras_top;
        end
    end

    assign jumpD          = validD && (is_j || is_jr);
    assign ras_predD      = validD && use_ras;
    assign jump_conflictD = validD && is_jr && hazard && !use_ras;

    assign fire = validD && !stallD && !jump_conflictD;
    assign push = fire && (is_jal || is_jalr);
    assign pop  = fire && is_ret && ras_nonempty;

    assign mispredictE = pred_vE && (rs_fwdE != tgtE);
    assign pc_fixE     = rs_fwdE;

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (mispredictE) begin
            // Wrong-path D instruction is squashed: flush the stack, ignore push/pop
            ras_count <= '0;
        end else if (push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_count != COUNT_W'(RAS_DEPTH)) begin
                ras_count <= ras_count + COUNT_W'(1);
            end
        end else if (pop) begin
            ras_ptr   <= ras_ptr - PTR_W'(1);
            ras_count <= ras_count - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !mispredictE && push) begin
            ras_mem[ras_ptr] <= pcplus4D + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_vE <= 1'b0;
            tgtE    <= '0;
        end else if (!stallE) begin
            pred_vE <= !flushE && fire && ras_predD && !mispredictE;
            tgtE    <= pc_jumpD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_hits   <= '0;
            ras_misses <= '0;
        end else if (pred_vE && !stallE) begin
            if (mispredictE) begin
                if (ras_misses != '1) begin
                    ras_misses <= ras_misses + CNT_W'(1);
                end
            end else if (ras_hits != '1) begin
                ras_hits <= ras_hits + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jump_ras_ctrl.sv
// ============================================================================
// Module      : tb_jump_ras_ctrl
// Description : Directed plus randomized bench for jump_ras_ctrl against a
//               queue-based return-stack model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_ras_ctrl;

    localparam int D  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, validD, stallD, stallE, flushE;
    logic [31:0]   instrD, pcplus4D, rd1D, rs_fwdE;
    logic          regwriteE, regwriteM, regwriteW;
    logic [4:0]    writeregE, writeregM, writeregW;
    logic          jumpD, jump_conflictD, ras_predD, mispredictE;
    logic [31:0]   pc_jumpD, pc_fixE;
    logic [CW-1:0] ras_hits, ras_misses;

    jump_ras_ctrl #(.RAS_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .validD(validD), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .instrD(instrD), .pcplus4D(pcplus4D), .rd1D(rd1D),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .rs_fwdE(rs_fwdE), .jumpD(jumpD), .jump_conflictD(jump_conflictD),
        .pc_jumpD(pc_jumpD), .ras_predD(ras_predD), .mispredictE(mispredictE),
        .pc_fixE(pc_fixE), .ras_hits(ras_hits), .ras_misses(ras_misses)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stack as a queue, newest at the back
    logic [31:0] ras_q[$];
    int          hits_m, miss_m;
    logic        pred_m;
    logic [31:0] tgt_m;
    logic        e_jump, e_conf, e_pred, e_misp, e_fire, e_link, e_ret;
    logic [31:0] e_pc;

    localparam int SAT = (1 << CW) - 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic eval_model();
        logic [4:0] rs;
        logic isj, isjr, haz, use_ras;
        rs      = instrD[25:21];
        isj     = (instrD[31:26] == 6'd2) || (instrD[31:26] == 6'd3);
        isjr    = (instrD[31:26] == 6'd0) && (instrD[5:0] == 6'd8 || instrD[5:0] == 6'd9);
        e_ret   = isjr && rs == 5'd31 && instrD[5:0] == 6'd8;
        e_link  = (instrD[31:26] == 6'd3) || (isjr && instrD[5:0] == 6'd9);
        haz     = (regwriteE && writeregE == rs) || (regwriteM && writeregM == rs)
                || (regwriteW && writeregW == rs);
        use_ras = e_ret && haz && ras_q.size() > 0;
        e_jump  = validD && (isj || isjr);
        e_pred  = validD && use_ras;
        e_conf  = validD && isjr && haz && !use_ras;
        e_pc    = isj ? {pcplus4D[31:28], instrD[25:0], 2'b00}
                : use_ras ? ras_q[$] : rd1D;
        e_misp  = pred_m && (rs_fwdE != tgt_m);
        e_fire  = validD && !stallD && !e_conf;
    endtask

    task automatic compare();
        @(negedge clk);
        eval_model();
        chk("jumpD", {31'd0, jumpD}, {31'd0, e_jump});
        chk("jump_conflictD", {31'd0, jump_conflictD}, {31'd0, e_conf});
        chk("ras_predD", {31'd0, ras_predD}, {31'd0, e_pred});
        if (e_jump) chk("pc_jumpD", pc_jumpD, e_pc);
        chk("mispredictE", {31'd0, mispredictE}, {31'd0, e_misp});
        chk("pc_fixE", pc_fixE, rs_fwdE);
        chk("ras_hits", 32'(ras_hits), 32'(hits_m));
        chk("ras_misses", 32'(ras_misses), 32'(miss_m));
    endtask

    task automatic advance();
        eval_model();
        if (rst) begin
            ras_q.delete();
            hits_m = 0; miss_m = 0; pred_m = 1'b0; tgt_m = '0;
        end else begin
            if (pred_m && !stallE) begin
                if (e_misp) miss_m = (miss_m == SAT) ? SAT : miss_m + 1;
                else        hits_m = (hits_m == SAT) ? SAT : hits_m + 1;
            end
            if (e_misp) ras_q.delete();
            else if (e_fire && e_link) begin
                ras_q.push_back(pcplus4D + 32'd4);
                if (ras_q.size() > D) void'(ras_q.pop_front());
            end else if (e_fire && e_ret && ras_q.size() > 0) void'(ras_q.pop_back());
            if (!stallE) begin
                pred_m = !flushE && e_fire && e_pred && !e_misp;
                tgt_m  = e_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_jal(input logic [31:0] t);
        return {6'b000011, t[27:2]};
    endfunction
    function automatic logic [31:0] mk_jr(input logic [4:0] r, input logic link);
        return {6'b0, r, 5'd0, (link ? 5'd31 : 5'd0), 5'd0, 5'b00100, link};
    endfunction

    task automatic idle();
        validD = 0; stallD = 0; stallE = 0; flushE = 0; rst = 0;
        instrD = 32'h0000_0000; regwriteE = 0; regwriteM = 0; regwriteW = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
    endtask

    task automatic step_jal(input logic [31:0] pc4);
        idle(); validD = 1; instrD = mk_jal(32'h0040_0000); pcplus4D = pc4;
        compare(); advance();
    endtask

    task automatic set_ret_hazE();
        idle(); validD = 1; instrD = mk_jr(5'd31, 1'b0); regwriteE = 1; writeregE = 5'd31;
    endtask

    initial begin
        logic [31:0] exp_t;
        idle(); rst = 1; pcplus4D = 0; rd1D = 32'h1234_5670; rs_fwdE = 0;
        hits_m = 0; miss_m = 0; pred_m = 0; tgt_m = 0;
        compare(); advance();
        idle(); compare();
        chk("reset_hits", 32'(ras_hits), 32'd0);
        chk("reset_mispredict", {31'd0, mispredictE}, 32'd0);
        advance();

        // jal at 0x100 then predicted return, resolved as a hit
        step_jal(32'h100);
        chk("model_count_after_jal", ras_q.size(), 32'd1);
        chk("model_top_after_jal", ras_q[$], 32'h104);
        set_ret_hazE(); compare();
        chk("ret_conflict", {31'd0, jump_conflictD}, 32'd0);
        chk("ret_pred", {31'd0, ras_predD}, 32'd1);
        chk("ret_target", pc_jumpD, 32'h104);
        advance();
        idle(); rs_fwdE = 32'h104; compare();
        chk("hit_no_mispredict", {31'd0, mispredictE}, 32'd0);
        advance();
        chk("model_hits", hits_m, 32'd1);

        // Same return resolved wrong
        step_jal(32'h100);
        set_ret_hazE(); compare(); advance();
        idle(); rs_fwdE = 32'h200; compare();
        chk("miss_mispredict", {31'd0, mispredictE}, 32'd1);
        chk("miss_fix", pc_fixE, 32'h200);
        advance();
        // RAS now empty: return with hazard in M must stall
        idle(); validD = 1; instrD = mk_jr(5'd31, 1'b0); regwriteM = 1; writeregM = 5'd31;
        rs_fwdE = 0; compare();
        chk("empty_ret_conflict", {31'd0, jump_conflictD}, 32'd1);
        chk("empty_ret_pred", {31'd0, ras_predD}, 32'd0);
        chk("misses_after_miss", 32'(ras_misses), 32'd1);
        advance();

        // jr $5 with hazard in W
        idle(); validD = 1; instrD = mk_jr(5'd5, 1'b0); regwriteW = 1; writeregW = 5'd5;
        rd1D = 32'hDEAD_BEE0; compare();
        chk("jr5_conflict", {31'd0, jump_conflictD}, 32'd1);
        chk("jr5_target", pc_jumpD, 32'hDEAD_BEE0);
        advance();

        // Overflow: D+1 pushes, D+1 returns; oldest entry lost
        for (int i = 0; i <= D; i++) step_jal(32'h100 * (i + 1));
        for (int i = 0; i <= D; i++) begin
            set_ret_hazE();
            rs_fwdE = (i == 0) ? 32'h0 : 32'h104 + 32'h100 * (D + 1 - i);
            compare();
            exp_t = 32'h104 + 32'h100 * (D - i);
            if (i < D) chk("overflow_pop", pc_jumpD, exp_t);
            else       chk("overflow_last_conflict", {31'd0, jump_conflictD}, 32'd1);
            advance();
        end
        idle(); rs_fwdE = 32'h204; compare(); advance();

        // jal held by stallD for 3 cycles: one push only
        for (int i = 0; i < 4; i++) begin
            idle(); validD = 1; instrD = mk_jal(32'h0); pcplus4D = 32'h700; stallD = (i < 3);
            compare(); advance();
        end
        chk("stall_single_push", ras_q.size(), 32'd1);
        set_ret_hazE(); compare();
        chk("stall_push_target", pc_jumpD, 32'h704);
        advance();
        idle(); rs_fwdE = 32'h704; compare(); advance();

        // Flushed prediction never resolves
        step_jal(32'h800);
        set_ret_hazE(); flushE = 1; compare(); advance();
        idle(); rs_fwdE = 32'hBAD0; compare();
        chk("flush_no_mispredict", {31'd0, mispredictE}, 32'd0);
        advance();

        // Reset mid-sequence
        step_jal(32'h900);
        idle(); rst = 1; validD = 1; instrD = mk_jal(32'h0); compare(); advance();
        set_ret_hazE(); compare();
        chk("post_reset_conflict", {31'd0, jump_conflictD}, 32'd1);
        chk("post_reset_hits", 32'(ras_hits), 32'd0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            idle();
            rst    = ($urandom_range(0, 199) == 0);
            validD = ($urandom_range(0, 9) != 0);
            stallD = ($urandom_range(0, 6) == 0);
            stallE = ($urandom_range(0, 9) == 0);
            flushE = ($urandom_range(0, 9) == 0);
            pcplus4D = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rd1D     = $urandom;
            case ($urandom_range(0, 7))
                0:       instrD = {6'b000010, 26'($urandom)};
                1, 2:    instrD = mk_jal($urandom);
                3, 4:    instrD = mk_jr(5'd31, 1'b0);
                5:       instrD = mk_jr(5'($urandom), 1'b1);
                6:       instrD = mk_jr(5'($urandom), 1'b0);
                default: instrD = {6'b100011, 26'($urandom)};
            endcase
            regwriteE = $urandom_range(0, 1); writeregE = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd31;
            regwriteM = $urandom_range(0, 1); writeregM = 5'($urandom);
            regwriteW = $urandom_range(0, 1); writeregW = 5'($urandom);
            rs_fwdE = ($urandom_range(0, 9) < 7) ? tgt_m : $urandom;
            compare(); advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
